// File: rtl/kf8259_pic_n.sv
`default_nettype none
// ============================================================================
// Module   : kf8259_pic_n
// Brief    : NUM_IRQ-line PIC: edge/level IRR, mask, nested/rotating priority,
//            registered vector handshake; KF8259_PIC_AUTO_EOI_EN adds AEOI.
// Revision : 1.0
// ============================================================================
module kf8259_pic_n #(
    parameter int         NUM_IRQ           = 8,
    parameter int         SYNC_STAGES       = 2,
    parameter logic [7:0] RESET_VECTOR_BASE = 8'h08
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               chip_select,
    input  logic               read_enable,
    input  logic               write_enable,
    input  logic [2:0]         address,
    input  logic [15:0]        data_bus_in,
    output logic [15:0]        data_bus_out,
    output logic               ack,
    input  logic [NUM_IRQ-1:0] interrupt_request,
    output logic               interrupt_to_cpu,
    input  logic               interrupt_acknowledge,
    output logic [7:0]         vector_out,
    output logic               vector_valid,
    output logic               spurious
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VECTOR = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [3:0] c_last_line = 4'(NUM_IRQ - 1);
    localparam logic [4:0] c_num_rank  = 5'(NUM_IRQ);

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];
    logic [NUM_IRQ-1:0] prev_q, prev_d, irr_q, irr_d, isr_q, isr_d;
    logic [NUM_IRQ-1:0] imr_q, imr_d, trig_q, trig_d;
    logic [7:0]         base_q, base_d, vec_q, vec_d;
    logic [3:0]         ptr_q, ptr_d;
    logic [15:0]        dout_q, dout_d;
    logic               rotate_q, rotate_d, aeoi_q, aeoi_d;
    logic               held_q, held_d, ack_q, ack_d, irq_q, irq_d;
    logic               valid_q, valid_d, spur_q, spur_d;

    logic [NUM_IRQ-1:0] sync_out, rise, pending, eoi_clr, take_mask;
    logic [3:0]         top_line, isr_line, cand_line, eoi_line;
    logic [4:0]         isr_rank, cand_rank;
    logic [15:0]        rdata;
    logic               cand_valid, strobe, accept, wr_acc, rd_acc, eoi_hit, ack_take;
    logic               unused_bits;

    assign unused_bits = ^data_bus_in[14:9];

    // Distance of a line from the current highest-priority line (0 = highest).
    function automatic logic [4:0] rank_of(input logic [3:0] line, input logic [3:0] top);
        logic [4:0] diff;
        diff = {1'b0, line} - {1'b0, top};
        if (line < top) diff = diff + c_num_rank;
        return diff;
    endfunction

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [3:0] line);
        logic [NUM_IRQ-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_IRQ; i++) m[i] = (4'(i) == line);
        return m;
    endfunction

    always_comb begin
        sync_out = sync_q[SYNC_STAGES-1];
        rise     = sync_out & ~prev_q;
        pending  = irr_q & ~imr_q;
        top_line = (rotate_q && ptr_q != c_last_line) ? ptr_q + 4'd1 : 4'd0;

        isr_rank  = c_num_rank;
        isr_line  = 4'd0;
        cand_rank = c_num_rank;
        cand_line = 4'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (isr_q[i] && rank_of(4'(i), top_line) < isr_rank) begin
                isr_rank = rank_of(4'(i), top_line);
                isr_line = 4'(i);
            end
            if (pending[i] && rank_of(4'(i), top_line) < cand_rank) begin
                cand_rank = rank_of(4'(i), top_line);
                cand_line = 4'(i);
            end
        end
        // A request only wins if it outranks everything currently in service.
        cand_valid = cand_rank < isr_rank;
    end

    always_comb begin
        strobe = chip_select & (read_enable | write_enable);
        accept = strobe & ~held_q;
        wr_acc = accept & write_enable;
        rd_acc = accept & read_enable;

        case (address)
            3'd0:    rdata = 16'(irr_q);
            3'd1:    rdata = 16'(isr_q);
            3'd2:    rdata = 16'(imr_q);
            3'd3:    rdata = 16'(trig_q);
            3'd4:    rdata = {6'd0, aeoi_q, rotate_q, base_q};
            3'd6:    rdata = {12'd0, ptr_q};
            default: rdata = 16'd0;
        endcase

        eoi_hit  = 1'b0;
        eoi_line = isr_line;
        if (wr_acc && address == 3'd5) begin
            if (data_bus_in[15]) begin
                eoi_hit = (isr_q != '0);
            end else begin
                eoi_line = data_bus_in[3:0];
                eoi_hit  = ({1'b0, data_bus_in[3:0]} < c_num_rank)
                           && (|(isr_q & onehot(data_bus_in[3:0])));
            end
        end
        eoi_clr   = eoi_hit ? onehot(eoi_line) : '0;
        ack_take  = (state_q == ST_IDLE) && interrupt_acknowledge;
        take_mask = (ack_take && cand_valid) ? onehot(cand_line) : '0;
    end

    always_comb begin
        sync_d[0] = interrupt_request;
        for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
        prev_d = sync_out;

        // A fresh edge in the acknowledge cycle is kept as a new request.
        irr_d = (trig_q & sync_out & ~take_mask)
              | (~trig_q & ((irr_q & ~take_mask) | rise));

        imr_d    = imr_q;
        trig_d   = trig_q;
        base_d   = base_q;
        rotate_d = rotate_q;
        aeoi_d   = aeoi_q;
        if (wr_acc) begin
            case (address)
                3'd2: imr_d  = data_bus_in[NUM_IRQ-1:0];
                3'd3: trig_d = data_bus_in[NUM_IRQ-1:0];
                3'd4: begin
                    base_d   = data_bus_in[7:0];
                    rotate_d = data_bus_in[8];
`ifdef KF8259_PIC_AUTO_EOI_EN
                    aeoi_d   = data_bus_in[9];
`else
                    aeoi_d   = 1'b0;
`endif
                end
                default: ;
            endcase
        end

        isr_d = (isr_q & ~eoi_clr) | (aeoi_q ? '0 : take_mask);
        ptr_d = ptr_q;
        if (rotate_q && eoi_hit) ptr_d = eoi_line;
        if (rotate_q && aeoi_q && ack_take && cand_valid) ptr_d = cand_line;

        held_d = strobe;
        ack_d  = accept;
        dout_d = rd_acc ? rdata : 16'd0;
        irq_d  = cand_valid;

        state_d = state_q;
        vec_d   = vec_q;
        valid_d = valid_q;
        spur_d  = spur_q;
        case (state_q)
            ST_IDLE: begin
                if (interrupt_acknowledge) begin
                    state_d = ST_VECTOR;
                    valid_d = 1'b1;
                    spur_d  = ~cand_valid;
                    vec_d   = cand_valid ? base_q + {4'd0, cand_line}
                                         : base_q + 8'(NUM_IRQ - 1);
                end
            end
            ST_VECTOR, ST_HOLD: begin
                if (interrupt_acknowledge) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    spur_d  = 1'b0;
                    vec_d   = 8'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                spur_d  = 1'b0;
                vec_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            state_q  <= ST_IDLE;
            prev_q   <= '0;
            irr_q    <= '0;
            isr_q    <= '0;
            imr_q    <= '1;
            trig_q   <= '0;
            base_q   <= RESET_VECTOR_BASE;
            rotate_q <= 1'b0;
            aeoi_q   <= 1'b0;
            ptr_q    <= c_last_line;
            held_q   <= 1'b0;
            ack_q    <= 1'b0;
            dout_q   <= 16'd0;
            irq_q    <= 1'b0;
            vec_q    <= 8'd0;
            valid_q  <= 1'b0;
            spur_q   <= 1'b0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
            state_q  <= state_d;
            prev_q   <= prev_d;
            irr_q    <= irr_d;
            isr_q    <= isr_d;
            imr_q    <= imr_d;
            trig_q   <= trig_d;
            base_q   <= base_d;
            rotate_q <= rotate_d;
            aeoi_q   <= aeoi_d;
            ptr_q    <= ptr_d;
            held_q   <= held_d;
            ack_q    <= ack_d;
            dout_q   <= dout_d;
            irq_q    <= irq_d;
            vec_q    <= vec_d;
            valid_q  <= valid_d;
            spur_q   <= spur_d;
        end
    end

    assign data_bus_out     = dout_q;
    assign ack              = ack_q;
    assign interrupt_to_cpu = irq_q;
    assign vector_out       = vec_q;
    assign vector_valid     = valid_q;
    assign spurious         = spur_q;

endmodule
`default_nettype wire

// File: tb/tb_kf8259_pic_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_kf8259_pic_n
// Brief    : Self-checking bench for kf8259_pic_n against a transaction-level
//            model; covers KF8259_PIC_AUTO_EOI_EN when defined.
// Revision : 1.0
// ============================================================================
module tb_kf8259_pic_n;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         chip_select, read_enable, write_enable;
    logic [2:0]   address;
    logic [15:0]  data_bus_in, data_bus_out;
    logic         ack;
    logic [N-1:0] interrupt_request;
    logic         interrupt_to_cpu, interrupt_acknowledge;
    logic [7:0]   vector_out;
    logic         vector_valid, spurious;

    kf8259_pic_n #(.NUM_IRQ(N), .SYNC_STAGES(2), .RESET_VECTOR_BASE(8'h08)) dut (
        .clk(clk), .reset_n(reset_n),
        .chip_select(chip_select), .read_enable(read_enable), .write_enable(write_enable),
        .address(address), .data_bus_in(data_bus_in), .data_bus_out(data_bus_out),
        .ack(ack), .interrupt_request(interrupt_request),
        .interrupt_to_cpu(interrupt_to_cpu), .interrupt_acknowledge(interrupt_acknowledge),
        .vector_out(vector_out), .vector_valid(vector_valid), .spurious(spurious)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (what software would believe the controller holds).
    logic [N-1:0] m_irr, m_isr, m_imr, m_trig, pins;
    logic [7:0]   m_base;
    logic         m_rot, m_aeoi;
    int           m_ptr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int top_line();
        return m_rot ? (m_ptr + 1) % N : 0;
    endfunction

    function automatic int isr_top();
        for (int k = 0; k < N; k++) begin
            int l;
            l = (top_line() + k) % N;
            if (m_isr[l]) return l;
        end
        return -1;
    endfunction

    // Walk lines in priority order; an in-service line blocks everything below it.
    function automatic int cand();
        for (int k = 0; k < N; k++) begin
            int l;
            l = (top_line() + k) % N;
            if (m_isr[l]) return -1;
            if (m_irr[l] && !m_imr[l]) return l;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_irr = '0; m_isr = '0; m_imr = '1; m_trig = '0;
        m_base = 8'h08; m_rot = 1'b0; m_aeoi = 1'b0; m_ptr = N - 1;
        pins = '0;
    endtask

    task automatic bus_acc(input logic wr, input logic [2:0] a, input logic [15:0] d,
                           output logic [15:0] q);
        @(posedge clk); #1;
        chip_select = 1'b1; write_enable = wr; read_enable = ~wr;
        address = a; data_bus_in = d;
        @(posedge clk); #1;
        check_eq("bus_ack", 32'(ack), 32'd1);
        q = data_bus_out;
        chip_select = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
        @(posedge clk); #1;
        check_eq("bus_ack_drop", 32'(ack), 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
        logic [15:0] q;
        bus_acc(1'b0, a, 16'h0000, q);
        check_eq(tag, 32'(q), 32'(exp));
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
        logic [15:0] q;
        int          l;
        bus_acc(1'b1, a, d, q);
        case (a)
            3'd2: m_imr  = d[N-1:0];
            3'd3: m_trig = d[N-1:0];
            3'd4: begin
                m_base = d[7:0];
                m_rot  = d[8];
`ifdef KF8259_PIC_AUTO_EOI_EN
                m_aeoi = d[9];
`endif
            end
            3'd5: begin
                l = d[15] ? isr_top() : int'(d[3:0]);
                if (l >= 0 && l < N && m_isr[l]) begin
                    m_isr[l] = 1'b0;
                    if (m_rot) m_ptr = l;
                end
            end
            default: ;
        endcase
        m_irr = (m_irr & ~m_trig) | (pins & m_trig);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic set_pins(input logic [N-1:0] v);
        m_irr = m_irr | (v & ~pins & ~m_trig);
        m_irr = (m_irr & ~m_trig) | (v & m_trig);
        pins = v;
        interrupt_request = v;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_ack(input string tag, output logic [7:0] vec_got);
        int         c;
        logic [7:0] ev;
        logic       es;
        c = cand();
        if (c >= 0) begin ev = m_base + 8'(c); es = 1'b0; end
        else begin ev = m_base + 8'(N - 1); es = 1'b1; end
        interrupt_acknowledge = 1'b1;
        @(posedge clk); #1;
        check_eq({tag, "_valid"}, 32'(vector_valid), 32'd1);
        check_eq({tag, "_vec"}, 32'(vector_out), 32'(ev));
        check_eq({tag, "_spur"}, 32'(spurious), 32'(es));
        vec_got = vector_out;
        @(posedge clk); #1;
        check_eq({tag, "_hold"}, 32'({vector_valid, vector_out}), 32'({1'b1, ev}));
        interrupt_acknowledge = 1'b0;
        @(posedge clk); #1;
        check_eq({tag, "_release"}, 32'({vector_valid, spurious}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        if (c >= 0) begin
            if (!m_aeoi) m_isr[c] = 1'b1;
            else if (m_rot) m_ptr = c;
            if (!m_trig[c]) m_irr[c] = 1'b0;
        end
    endtask

    task automatic chk_int(input string tag);
        check_eq(tag, 32'(interrupt_to_cpu), 32'(cand() >= 0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected self-finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   vg;
        logic [N-1:0] pv;
        reset_n = 1'b0; chip_select = 1'b0; read_enable = 1'b0; write_enable = 1'b0;
        address = 3'd0; data_bus_in = 16'h0000; interrupt_request = '0;
        interrupt_acknowledge = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outputs", 32'({ack, interrupt_to_cpu, vector_valid, spurious, vector_out}), 32'd0);
        reset_n = 1'b1;

        rd_chk("rst_imr", 3'd2, 16'h00FF);
        rd_chk("rst_ctrl", 3'd4, 16'h0008);
        rd_chk("rst_prio", 3'd6, 16'h0007);
        rd_chk("rst_trig", 3'd3, 16'h0000);
        rd_chk("addr7", 3'd7, 16'h0000);
        check_eq("rst_int", 32'(interrupt_to_cpu), 32'd0);

        // Strobe held for several cycles is accepted only once.
        @(posedge clk); #1;
        chip_select = 1'b1; read_enable = 1'b1; address = 3'd2;
        @(posedge clk); #1;
        check_eq("held_ack1", 32'({ack, data_bus_out}), 32'h1_00FF);
        @(posedge clk); #1;
        check_eq("held_ack2", 32'(ack), 32'd0);
        @(posedge clk); #1;
        check_eq("held_ack3", 32'({ack, data_bus_out}), 32'd0);
        chip_select = 1'b0; read_enable = 1'b0;

        // IR3 edge: pin to interrupt_to_cpu takes 4 cycles.
        wr_reg(3'd2, 16'h0000);
        interrupt_request = 8'h08; pins = 8'h08; m_irr[3] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("tp_int_early", 32'(interrupt_to_cpu), 32'd0);
        @(posedge clk); #1;
        check_eq("tp_int_4cyc", 32'(interrupt_to_cpu), 32'd1);
        set_pins(8'h00);
        do_ack("tp_ack3", vg);
        check_eq("tp_vec3", 32'(vg), 32'h0B);
        rd_chk("tp_isr3", 3'd1, 16'h0008);
        rd_chk("tp_irr3", 3'd0, 16'h0000);
        wr_reg(3'd5, 16'h0003);

        // Nesting: IR5 in service blocks IR6 but not IR2.
        set_pins(8'h20); set_pins(8'h00);
        do_ack("nest_ack5", vg);
        set_pins(8'h44); set_pins(8'h00);
        do_ack("nest_ack2", vg);
        check_eq("nest_vec2", 32'(vg), 32'h0A);
        wr_reg(3'd5, 16'h8000);
        rd_chk("nest_isr", 3'd1, 16'h0020);
        check_eq("nest_blocked", 32'(interrupt_to_cpu), 32'd0);
        wr_reg(3'd5, 16'h0005);
        check_eq("nest_unblocked", 32'(interrupt_to_cpu), 32'd1);
        do_ack("nest_ack6", vg);
        check_eq("nest_vec6", 32'(vg), 32'h0E);
        wr_reg(3'd5, 16'h8000);

        // Rotation.
        wr_reg(3'd4, 16'h0108);
        set_pins(8'h03); set_pins(8'h00);
        do_ack("rot_ack0", vg);
        check_eq("rot_vec0", 32'(vg), 32'h08);
        wr_reg(3'd5, 16'h8000);
        rd_chk("rot_prio", 3'd6, 16'h0000);
        do_ack("rot_ack1", vg);
        check_eq("rot_vec1", 32'(vg), 32'h09);
        wr_reg(3'd5, 16'h8000);
        wr_reg(3'd4, 16'h0008);

        // Nothing pending.
        do_ack("spur_ack", vg);
        check_eq("spur_vec", 32'(vg), 32'h0F);
        rd_chk("spur_isr", 3'd1, 16'h0000);

        // Randomised traffic against the model.
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 6))
                0: wr_reg(3'd2, 16'($urandom) & 16'($urandom));
                1: wr_reg(3'd3, 16'($urandom));
                2, 3: begin pv = N'($urandom); set_pins(pv); end
                4: do_ack("r_ack", vg);
                5: wr_reg(3'd5, ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'($urandom_range(0, 15)));
                default: wr_reg(3'd4, {7'd0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))});
            endcase
            chk_int("r_int");
            rd_chk("r_irr", 3'd0, 16'(m_irr));
            rd_chk("r_isr", 3'd1, 16'(m_isr));
            if (it % 8 == 0) begin
                rd_chk("r_prio", 3'd6, 16'(m_ptr));
                rd_chk("r_ctrl", 3'd4, {6'd0, m_aeoi, m_rot, m_base});
                rd_chk("r_imr", 3'd2, 16'(m_imr));
                rd_chk("r_trig", 3'd3, 16'(m_trig));
            end
        end

        // Asynchronous reset in the middle of a handshake.
        interrupt_acknowledge = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("hs_hold_valid", 32'(vector_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("hs_rst_outputs", 32'({vector_valid, spurious, interrupt_to_cpu, vector_out}), 32'd0);
        interrupt_acknowledge = 1'b0;
        interrupt_request = '0;
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        rd_chk("hs_isr", 3'd1, 16'h0000);
        rd_chk("hs_imr", 3'd2, 16'h00FF);
        rd_chk("hs_irr", 3'd0, 16'h0000);

        // CTRL[9]: auto-EOI when compiled in, otherwise ignored.
        wr_reg(3'd2, 16'h0000);
        wr_reg(3'd4, 16'h0208);
`ifdef KF8259_PIC_AUTO_EOI_EN
        rd_chk("aeoi_ctrl", 3'd4, 16'h0208);
`else
        rd_chk("aeoi_ctrl", 3'd4, 16'h0008);
`endif
        set_pins(8'h10); set_pins(8'h00);
        do_ack("aeoi_ack", vg);
        check_eq("aeoi_vec", 32'(vg), 32'h0C);
        rd_chk("aeoi_isr", 3'd1, 16'(m_isr));
        chk_int("aeoi_int");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
